hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 171 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline.
// Detects load-use hazards, redirects from EX and data-memory wait states, and
// drives the stage-register hold/flush controls. It also flags memory-wait
// timeouts with a sticky error and keeps saturating stall/flush counters.
module hazard_ctrl #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_AA,
    input  logic [4:0]       ID_BA,
    input  logic             ID_UA,
    input  logic             ID_UB,
    input  logic [4:0]       EX_DA,
    input  logic             EX_RW,
    input  logic             EX_MR,
    input  logic             EX_Redirect,
    input  logic             MEM_Req,
    input  logic             MEM_Ready,
    input  logic             Cnt_Clr,
    output logic             PC_Hold,
    output logic             IF_ID_Hold,
    output logic             ID_EX_Hold,
    output logic             EX_MEM_Hold,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Flush,
    output logic             MEM_WB_Flush,
    output logic             Mem_Err,
    output logic [CNT_W-1:0] Stall_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT, ERR} state_t;

    // The wait counter is compared against TIMEOUT-1 because it holds the
    // number of wait cycles already completed before the current one.
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       mem_wait;
    logic       lu_hit;
    logic       wait_expired;

    assign mem_wait     = MEM_Req & ~MEM_Ready;
    assign lu_hit       = EX_MR & EX_RW & (EX_DA != 5'd0) &
                          ((ID_UA & (EX_DA == ID_AA)) | (ID_UB & (EX_DA == ID_BA)));
    assign wait_expired = mem_wait & (wait_cnt >= TIMEOUT_M1);

    // State register; reset abandons any wait or error immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and hold/flush decode; reset forces every control low.
    always_comb begin
        state_next   = state;
        PC_Hold      = 1'b0;
        IF_ID_Hold   = 1'b0;
        ID_EX_Hold   = 1'b0;
        EX_MEM_Hold  = 1'b0;
        IF_ID_Flush  = 1'b0;
        ID_EX_Flush  = 1'b0;
        MEM_WB_Flush = 1'b0;
        case (state)
            RUN, LU_STALL: begin
                if (mem_wait) begin
                    PC_Hold      = 1'b1;
                    IF_ID_Hold   = 1'b1;
                    ID_EX_Hold   = 1'b1;
                    EX_MEM_Hold  = 1'b1;
                    MEM_WB_Flush = 1'b1;
                    state_next   = wait_expired ? ERR : MEM_WAIT;
                end else if (EX_Redirect) begin
                    IF_ID_Flush = 1'b1;
                    ID_EX_Flush = 1'b1;
                    state_next  = RUN;
                end else if ((state == RUN) && lu_hit) begin
                    PC_Hold     = 1'b1;
                    IF_ID_Hold  = 1'b1;
                    ID_EX_Flush = 1'b1;
                    state_next  = LU_STALL;
                end else begin
                    state_next = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_wait) begin
                    PC_Hold      = 1'b1;
                    IF_ID_Hold   = 1'b1;
                    ID_EX_Hold   = 1'b1;
                    EX_MEM_Hold  = 1'b1;
                    MEM_WB_Flush = 1'b1;
                    state_next   = wait_expired ? ERR : MEM_WAIT;
                end else begin
                    state_next = RUN;
                end
            end
            ERR: begin
                PC_Hold      = 1'b1;
                IF_ID_Hold   = 1'b1;
                ID_EX_Hold   = 1'b1;
                EX_MEM_Hold  = 1'b1;
                MEM_WB_Flush = 1'b1;
                state_next   = ERR;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        if (rst) begin
            state_next   = RUN;
            PC_Hold      = 1'b0;
            IF_ID_Hold   = 1'b0;
            ID_EX_Hold   = 1'b0;
            EX_MEM_Hold  = 1'b0;
            IF_ID_Flush  = 1'b0;
            ID_EX_Flush  = 1'b0;
            MEM_WB_Flush = 1'b0;
        end
    end

    // Consecutive memory-wait cycle counter, saturating so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= 8'd0;
        end else if (!mem_wait) begin
            wait_cnt <= 8'd0;
        end else if (wait_cnt != 8'hFF) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Sticky timeout flag, set on the same edge the FSM enters ERR.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Mem_Err <= 1'b0;
        end else if (state_next == ERR) begin
            Mem_Err <= 1'b1;
        end
    end

    // Stall counter: one count per held-PC cycle, clear wins over increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Stall_Cnt <= '0;
        end else if (Cnt_Clr) begin
            Stall_Cnt <= '0;
        end else if (PC_Hold && (Stall_Cnt != '1)) begin
            Stall_Cnt <= Stall_Cnt + 1'b1;
        end
    end

    // Flush counter: one count per cycle with a front-end flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Flush_Cnt <= '0;
        end else if (Cnt_Clr) begin
            Flush_Cnt <= '0;
        end else if ((IF_ID_Flush || ID_EX_Flush) && (Flush_Cnt != '1)) begin
            Flush_Cnt <= Flush_Cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;

    // Expected output vector order: {PC, IF_ID_H, ID_EX_H, EX_MEM_H, IF_ID_F, ID_EX_F, MEM_WB_F}
    localparam logic [6:0] O_NONE  = 7'b0000000;
    localparam logic [6:0] O_WAIT  = 7'b1111001;
    localparam logic [6:0] O_REDIR = 7'b0000110;
    localparam logic [6:0] O_LU    = 7'b1100010;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       id_aa, id_ba, ex_da;
    logic             id_ua, id_ub, ex_rw, ex_mr, ex_redirect;
    logic             mem_req, mem_ready, cnt_clr;
    logic             pc_hold, if_id_hold, id_ex_hold, ex_mem_hold;
    logic             if_id_flush, id_ex_flush, mem_wb_flush, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit         m_err;
    bit         m_in_wait;
    bit         m_bubble;
    int         m_wait_run;
    int         m_stall;
    int         m_flush;
    logic [6:0] m_exp;

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .ID_AA(id_aa), .ID_BA(id_ba), .ID_UA(id_ua), .ID_UB(id_ub),
        .EX_DA(ex_da), .EX_RW(ex_rw), .EX_MR(ex_mr), .EX_Redirect(ex_redirect),
        .MEM_Req(mem_req), .MEM_Ready(mem_ready), .Cnt_Clr(cnt_clr),
        .PC_Hold(pc_hold), .IF_ID_Hold(if_id_hold), .ID_EX_Hold(id_ex_hold),
        .EX_MEM_Hold(ex_mem_hold), .IF_ID_Flush(if_id_flush),
        .ID_EX_Flush(id_ex_flush), .MEM_WB_Flush(mem_wb_flush),
        .Mem_Err(mem_err), .Stall_Cnt(stall_cnt), .Flush_Cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] dut_vec();
        return {pc_hold, if_id_hold, id_ex_hold, ex_mem_hold,
                if_id_flush, id_ex_flush, mem_wb_flush};
    endfunction

    function automatic bit load_use();
        return ex_mr && ex_rw && (ex_da != 0) &&
               ((id_ua && ex_da == id_aa) || (id_ub && ex_da == id_ba));
    endfunction

    function automatic logic [6:0] model_out();
        bit mw = mem_req && !mem_ready;
        if (rst)                     return O_NONE;
        if (m_err)                   return O_WAIT;
        if (mw)                      return O_WAIT;
        if (m_in_wait)               return O_NONE;
        if (ex_redirect)             return O_REDIR;
        if (!m_bubble && load_use()) return O_LU;
        return O_NONE;
    endfunction

    task automatic model_reset();
        m_err = 0; m_in_wait = 0; m_bubble = 0;
        m_wait_run = 0; m_stall = 0; m_flush = 0;
    endtask

    // Advance the model across one rising edge using the inputs held before it.
    task automatic model_step();
        bit mw = mem_req && !mem_ready;
        if (rst) begin
            model_reset();
            return;
        end
        if (m_exp[6] && m_stall < CMAX) m_stall++;
        if ((m_exp[2] || m_exp[1]) && m_flush < CMAX) m_flush++;
        if (cnt_clr) begin
            m_stall = 0;
            m_flush = 0;
        end
        if (!m_err) begin
            m_wait_run = mw ? m_wait_run + 1 : 0;
            if (mw && m_wait_run >= TIMEOUT) m_err = 1;
            m_in_wait = mw;
            m_bubble  = (m_exp == O_LU);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit mr, input bit rw, input logic [4:0] da,
                                 input logic [4:0] aa, input bit ua, input logic [4:0] ba,
                                 input bit ub, input bit redir, input bit req, input bit rdy,
                                 input bit clr);
        rst = r; ex_mr = mr; ex_rw = rw; ex_da = da; id_aa = aa; id_ua = ua;
        id_ba = ba; id_ub = ub; ex_redirect = redir; mem_req = req;
        mem_ready = rdy; cnt_clr = clr;
        #3;
    endtask

    task automatic idle(input bit clr);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, clr);
    endtask

    // Compare the DUT against the model, then cross the next rising edge.
    task automatic checkOutput();
        if (rst) model_reset();
        m_exp = model_out();
        chk("hz_out", {25'd0, dut_vec()}, {25'd0, m_exp});
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        chk("mem_err", {31'd0, mem_err}, {31'd0, m_err});
        @(posedge clk);
        model_step();
        #1;
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;

        // Reset with a live load-use pattern on the inputs
        applyStimulus(1, 1, 1, 5, 5, 1, 0, 0, 0, 0, 1, 0);
        chk("rst_pc_hold", {31'd0, pc_hold}, 0);
        chk("rst_id_ex_flush", {31'd0, id_ex_flush}, 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        checkOutput();
        idle(0); checkOutput();

        // Load-use: exactly one bubble even with inputs unchanged
        applyStimulus(0, 1, 1, 5, 5, 1, 0, 0, 0, 0, 1, 0);
        chk("lu_hold", {29'd0, pc_hold, if_id_hold, id_ex_flush}, 32'b111);
        checkOutput();
        applyStimulus(0, 1, 1, 5, 5, 1, 0, 0, 0, 0, 1, 0);
        chk("lu_second", {29'd0, pc_hold, if_id_hold, id_ex_flush}, 0);
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        checkOutput();
        idle(1); checkOutput();

        // Register x0 never creates a hazard
        applyStimulus(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0);
        chk("x0_none", {25'd0, dut_vec()}, 0);
        checkOutput();

        // Redirect wins over a simultaneous load-use
        applyStimulus(0, 1, 1, 5, 5, 1, 0, 0, 1, 0, 1, 0);
        chk("redir_flush", {29'd0, pc_hold, if_id_flush, id_ex_flush}, 32'b011);
        checkOutput();
        idle(0);
        chk("redir_flush_cnt", 32'(flush_cnt), 1);
        checkOutput();

        // Memory wait outranks redirect; release cycle is quiet, then redirect acts
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
            chk("mw_hold", {25'd0, dut_vec()}, {25'd0, O_WAIT});
            checkOutput();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        chk("mw_release", {25'd0, dut_vec()}, 0);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("mw_then_redir", {25'd0, dut_vec()}, {25'd0, O_REDIR});
        checkOutput();

        // Reset mid-wait: first cycle after release behaves as RUN
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            checkOutput();
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
        chk("rst_wait_redir", {25'd0, dut_vec()}, {25'd0, O_REDIR});
        checkOutput();

        // Timeout after the fourth wait cycle, then error persists past ready
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
            chk("to_no_err_yet", {31'd0, mem_err}, 0);
            checkOutput();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        chk("to_mem_err", {31'd0, mem_err}, 1);
        chk("to_err_hold", {25'd0, dut_vec()}, {25'd0, O_WAIT});
        checkOutput();
        for (int i = 0; i < 20; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0);
            checkOutput();
        end
        chk("sat_stall_cnt", 32'(stall_cnt), 15);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        checkOutput();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("clr_stall_cnt", 32'(stall_cnt), 0);
        chk("err_sticky", {31'd0, mem_err}, 1);
        checkOutput();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("err_rst_clear", {31'd0, mem_err}, 0);
        chk("err_rst_hold", {31'd0, pc_hold}, 0);
        checkOutput();
        idle(0); checkOutput();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(99) < 2),
                          ($urandom_range(99) < 60), ($urandom_range(99) < 70),
                          5'($urandom_range(3)), 5'($urandom_range(3)),
                          ($urandom_range(99) < 70), 5'($urandom_range(3)),
                          ($urandom_range(99) < 50), ($urandom_range(99) < 15),
                          ($urandom_range(99) < 30), ($urandom_range(99) < 55),
                          ($urandom_range(99) < 3));
            checkOutput();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
